// File: rtl/sacache2.sv
// Two-way set-associative cache with true-LRU replacement, two registered read
// ports, one insert port and a registered eviction report for displaced lines.
module sacache2 #(
  parameter int SETBITS = 2,
  parameter int DWIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       raddr0,
  input  logic              re0,
  output logic [DWIDTH-1:0] data_out0,
  output logic              valid0,
  input  logic [15:0]       raddr1,
  input  logic              re1,
  output logic [DWIDTH-1:0] data_out1,
  output logic              valid1,
  input  logic [15:0]       insert_adr,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              valid_in,
  output logic [15:0]       evicted_adr,
  output logic [DWIDTH-1:0] evicted_data,
  output logic              evicted_valid
);

  localparam int SETS = 1 << SETBITS;
  localparam int TW   = 16 - SETBITS;

  logic [1:0]        val_q [SETS];
  logic [TW-1:0]     tag_q [SETS][2];
  logic [DWIDTH-1:0] dat_q [SETS][2];
  logic [SETS-1:0]   lru_q, lru_d;

  logic [15:0]        raddr [2];
  logic               re    [2];
  logic [SETBITS-1:0] rset  [2];
  logic               hit   [2];
  logic               hway  [2];

  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;
  assign re[0]    = re0;
  assign re[1]    = re1;

  // Read stage: lookup against pre-edge array contents, result registered.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [TW-1:0]     tag;
    logic              m0, m1;
    logic              vld_q;
    logic [DWIDTH-1:0] rdat_q;

    assign rset[p]  = raddr[p][SETBITS-1:0];
    assign tag      = raddr[p][15:SETBITS];
    assign m0       = val_q[rset[p]][0] && (tag_q[rset[p]][0] == tag);
    assign m1       = val_q[rset[p]][1] && (tag_q[rset[p]][1] == tag);
    assign hit[p]   = re[p] && (m0 || m1);
    assign hway[p]  = !m0;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        rdat_q <= '0;
      end else begin
        vld_q <= hit[p];
        if (hit[p]) rdat_q <= dat_q[rset[p]][hway[p]];
      end
    end
  end

  assign valid0    = g_port[0].vld_q;
  assign data_out0 = g_port[0].rdat_q;
  assign valid1    = g_port[1].vld_q;
  assign data_out1 = g_port[1].rdat_q;

  logic [SETBITS-1:0] iset;
  logic [TW-1:0]      itag;
  logic               ip0, ip1, iway, ievict;

  assign iset = insert_adr[SETBITS-1:0];
  assign itag = insert_adr[15:SETBITS];

  // Way selection: existing tag, then free way (way 0 first), then LRU victim.
  always_comb begin
    iway   = 1'b0;
    ievict = 1'b0;
    ip0    = val_q[iset][0] && (tag_q[iset][0] == itag);
    ip1    = val_q[iset][1] && (tag_q[iset][1] == itag);
    if (ip0)                  iway = 1'b0;
    else if (ip1)             iway = 1'b1;
    else if (!val_q[iset][0]) iway = 1'b0;
    else if (!val_q[iset][1]) iway = 1'b1;
    else begin
      iway   = lru_q[iset];
      ievict = 1'b1;
    end
  end

  // Later events to the same set override earlier ones: port 0, port 1, insert.
  always_comb begin
    lru_d = lru_q;
    if (hit[0])   lru_d[rset[0]] = ~hway[0];
    if (hit[1])   lru_d[rset[1]] = ~hway[1];
    if (valid_in) lru_d[iset]    = ~iway;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) val_q[s] <= '0;
      lru_q <= '0;
    end else begin
      lru_q <= lru_d;
      if (valid_in) val_q[iset][iway] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && valid_in) begin
      tag_q[iset][iway] <= itag;
      dat_q[iset][iway] <= data_in;
    end
  end

  logic              evv_q;
  logic [15:0]       eva_q;
  logic [DWIDTH-1:0] evd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evv_q <= 1'b0;
      eva_q <= '0;
      evd_q <= '0;
    end else begin
      evv_q <= valid_in && ievict;
      if (valid_in && ievict) begin
        eva_q <= {tag_q[iset][iway], iset};
        evd_q <= dat_q[iset][iway];
      end
    end
  end

  assign evicted_valid = evv_q;
  assign evicted_adr   = eva_q;
  assign evicted_data  = evd_q;

endmodule

// File: tb/tb_sacache2.sv
// Scoreboard bench for sacache2 (SETBITS=2, DWIDTH=16): expected read results
// are queued when a read is issued and compared one cycle later.
module tb_sacache2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] raddr0, raddr1, insert_adr, data_in;
  logic        re0, re1, valid_in;
  logic [15:0] data_out0, data_out1, evicted_adr, evicted_data;
  logic        valid0, valid1, evicted_valid;

  typedef struct {
    logic        v;
    logic [15:0] d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sacache2 #(.SETBITS(2), .DWIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .raddr0(raddr0), .re0(re0), .data_out0(data_out0), .valid0(valid0),
    .raddr1(raddr1), .re1(re1), .data_out1(data_out1), .valid1(valid1),
    .insert_adr(insert_adr), .data_in(data_in), .valid_in(valid_in),
    .evicted_adr(evicted_adr), .evicted_data(evicted_data),
    .evicted_valid(evicted_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    re0 = 1'b0;
    re1 = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic ins(input logic [15:0] a, input logic [15:0] d);
    valid_in = 1'b1;
    insert_adr = a;
    data_in = d;
  endtask

  task automatic rd0(input logic [15:0] a, input logic v, input logic [15:0] d);
    exp_t e;
    re0 = 1'b1;
    raddr0 = a;
    e.v = v;
    e.d = d;
    q0.push_back(e);
  endtask

  task automatic rd1(input logic [15:0] a, input logic v, input logic [15:0] d);
    exp_t e;
    re1 = 1'b1;
    raddr1 = a;
    e.v = v;
    e.d = d;
    q1.push_back(e);
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset;
    exp_t e;
    idle();
    rst = 1'b1;
    ins(16'h0010, 16'h9999);
    tick();
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if ({valid0, valid1, evicted_valid} !== 3'b000 || data_out0 !== 16'h0 ||
        data_out1 !== 16'h0 || evicted_adr !== 16'h0 || evicted_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: v0=%b v1=%b ev=%b d0=%h d1=%h ea=%h ed=%h, required all zero",
               valid0, valid1, evicted_valid, data_out0, data_out1, evicted_adr, evicted_data);
    end
    rd0(16'h0010, 1'b0, 16'h0);
    rd1(16'h0010, 1'b0, 16'h0);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v) begin
      errors++;
      $display("FAIL reset_read0: valid0=%b required %b", valid0, e.v);
    end
    e = q1.pop_front();
    checks++;
    if (valid1 !== e.v || evicted_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_read1: valid1=%b ev=%b required %b/0", valid1, evicted_valid, e.v);
    end
  endtask

  task automatic test_hit;
    exp_t e;
    do_reset();
    ins(16'h0010, 16'hAAAA);
    tick();
    idle();
    rd0(16'h0010, 1'b1, 16'hAAAA);
    rd1(16'h0014, 1'b0, 16'h0);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d)) begin
      errors++;
      $display("FAIL hit_port0: valid=%b data=%h required valid=%b data=%h", valid0, data_out0, e.v, e.d);
    end
    e = q1.pop_front();
    checks++;
    if (valid1 !== e.v || evicted_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_port1_miss: valid=%b ev=%b required valid=%b ev=0", valid1, evicted_valid, e.v);
    end
  endtask

  task automatic test_eviction;
    exp_t e;
    do_reset();
    ins(16'h0010, 16'hAAAA);
    tick();
    ins(16'h0020, 16'hBBBB);
    tick();
    idle();
    rd0(16'h0010, 1'b1, 16'hAAAA);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d)) begin
      errors++;
      $display("FAIL evict_touch: valid=%b data=%h required valid=%b data=%h", valid0, data_out0, e.v, e.d);
    end
    ins(16'h0030, 16'hCCCC);
    tick();
    idle();
    checks++;
    if (evicted_valid !== 1'b1 || evicted_adr !== 16'h0020 || evicted_data !== 16'hBBBB) begin
      errors++;
      $display("FAIL evict_report: ev=%b adr=%h data=%h required 1/0020/bbbb",
               evicted_valid, evicted_adr, evicted_data);
    end
    tick();
    checks++;
    if (evicted_valid !== 1'b0) begin
      errors++;
      $display("FAIL evict_pulse: ev=%b required 0", evicted_valid);
    end
    rd0(16'h0010, 1'b1, 16'hAAAA);
    rd1(16'h0030, 1'b1, 16'hCCCC);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d)) begin
      errors++;
      $display("FAIL evict_keep: valid=%b data=%h required valid=%b data=%h", valid0, data_out0, e.v, e.d);
    end
    e = q1.pop_front();
    checks++;
    if (valid1 !== e.v || (e.v && data_out1 !== e.d)) begin
      errors++;
      $display("FAIL evict_new: valid=%b data=%h required valid=%b data=%h", valid1, data_out1, e.v, e.d);
    end
    rd0(16'h0020, 1'b0, 16'h0);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v) begin
      errors++;
      $display("FAIL evict_gone: valid=%b required %b", valid0, e.v);
    end
  endtask

  task automatic test_overwrite;
    exp_t e;
    do_reset();
    ins(16'h0010, 16'h1111);
    tick();
    ins(16'h0010, 16'h2222);
    tick();
    ins(16'h0020, 16'h3333);
    tick();
    idle();
    checks++;
    if (evicted_valid !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_noevict: ev=%b adr=%h required ev=0", evicted_valid, evicted_adr);
    end
    rd0(16'h0010, 1'b1, 16'h2222);
    rd1(16'h0020, 1'b1, 16'h3333);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d)) begin
      errors++;
      $display("FAIL overwrite_data: valid=%b data=%h required valid=%b data=%h", valid0, data_out0, e.v, e.d);
    end
    e = q1.pop_front();
    checks++;
    if (valid1 !== e.v || (e.v && data_out1 !== e.d)) begin
      errors++;
      $display("FAIL overwrite_fill: valid=%b data=%h required valid=%b data=%h", valid1, data_out1, e.v, e.d);
    end
  endtask

  task automatic test_same_cycle;
    exp_t e;
    do_reset();
    ins(16'h0040, 16'hDDDD);
    rd0(16'h0040, 1'b0, 16'h0);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v) begin
      errors++;
      $display("FAIL same_cycle_miss: valid=%b required %b", valid0, e.v);
    end
    ins(16'h0040, 16'hEEEE);
    rd0(16'h0040, 1'b1, 16'hDDDD);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d)) begin
      errors++;
      $display("FAIL same_cycle_old: valid=%b data=%h required valid=%b data=%h", valid0, data_out0, e.v, e.d);
    end
    rd0(16'h0040, 1'b1, 16'hEEEE);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d)) begin
      errors++;
      $display("FAIL same_cycle_next: valid=%b data=%h required valid=%b data=%h", valid0, data_out0, e.v, e.d);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    ins(16'h0012, 16'h0001);
    tick();
    ins(16'h0022, 16'h0002);
    tick();
    ins(16'h0032, 16'h0003);
    tick();
    checks++;
    if (evicted_valid !== 1'b1 || evicted_adr !== 16'h0012 || evicted_data !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_first: ev=%b adr=%h data=%h required 1/0012/0001",
               evicted_valid, evicted_adr, evicted_data);
    end
    ins(16'h0042, 16'h0004);
    tick();
    idle();
    checks++;
    if (evicted_valid !== 1'b1 || evicted_adr !== 16'h0022 || evicted_data !== 16'h0002) begin
      errors++;
      $display("FAIL b2b_second: ev=%b adr=%h data=%h required 1/0022/0002",
               evicted_valid, evicted_adr, evicted_data);
    end
    tick();
    checks++;
    if (evicted_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop: ev=%b required 0", evicted_valid);
    end
  endtask

  task automatic test_lru_order;
    exp_t e;
    do_reset();
    ins(16'h0013, 16'h00A1);
    tick();
    ins(16'h0023, 16'h00A2);
    tick();
    idle();
    rd0(16'h0013, 1'b1, 16'h00A1);
    rd1(16'h0023, 1'b1, 16'h00A2);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d)) begin
      errors++;
      $display("FAIL lru_dual0: valid=%b data=%h required valid=%b data=%h", valid0, data_out0, e.v, e.d);
    end
    e = q1.pop_front();
    checks++;
    if (valid1 !== e.v || (e.v && data_out1 !== e.d)) begin
      errors++;
      $display("FAIL lru_dual1: valid=%b data=%h required valid=%b data=%h", valid1, data_out1, e.v, e.d);
    end
    ins(16'h0033, 16'h00A3);
    tick();
    idle();
    checks++;
    if (evicted_valid !== 1'b1 || evicted_adr !== 16'h0013 || evicted_data !== 16'h00A1) begin
      errors++;
      $display("FAIL lru_port1_wins: ev=%b adr=%h data=%h required 1/0013/00a1",
               evicted_valid, evicted_adr, evicted_data);
    end
    ins(16'h0033, 16'h00B3);
    rd0(16'h0023, 1'b1, 16'h00A2);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || (e.v && data_out0 !== e.d) || evicted_valid !== 1'b0) begin
      errors++;
      $display("FAIL lru_mixed_read: valid=%b data=%h ev=%b required valid=%b data=%h ev=0",
               valid0, data_out0, evicted_valid, e.v, e.d);
    end
    ins(16'h0043, 16'h00A4);
    tick();
    idle();
    checks++;
    if (evicted_valid !== 1'b1 || evicted_adr !== 16'h0023 || evicted_data !== 16'h00A2) begin
      errors++;
      $display("FAIL lru_insert_wins: ev=%b adr=%h data=%h required 1/0023/00a2",
               evicted_valid, evicted_adr, evicted_data);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    do_reset();
    ins(16'h0011, 16'h0101);
    tick();
    ins(16'h0021, 16'h0202);
    tick();
    rst = 1'b1;
    ins(16'h0031, 16'h0303);
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (evicted_valid !== 1'b0 || evicted_adr !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_noevict: ev=%b adr=%h required 0/0000", evicted_valid, evicted_adr);
    end
    rd0(16'h0011, 1'b0, 16'h0);
    rd1(16'h0021, 1'b0, 16'h0);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v) begin
      errors++;
      $display("FAIL reset_mid_read0: valid=%b required %b", valid0, e.v);
    end
    e = q1.pop_front();
    checks++;
    if (valid1 !== e.v) begin
      errors++;
      $display("FAIL reset_mid_read1: valid=%b required %b", valid1, e.v);
    end
    rd0(16'h0031, 1'b0, 16'h0);
    tick();
    idle();
    e = q0.pop_front();
    checks++;
    if (valid0 !== e.v || data_out0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_insert: valid=%b data=%h required %b/0000", valid0, data_out0, e.v);
    end
  endtask

  initial begin
    rst = 1'b0;
    raddr0 = '0;
    raddr1 = '0;
    insert_adr = '0;
    data_in = '0;
    idle();
    test_reset();
    test_hit();
    test_eviction();
    test_overwrite();
    test_same_cycle();
    test_back_to_back();
    test_lru_order();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sacache2.md
# sacache2

Two-way set-associative successor to the direct-mapped cache, with the same two registered read ports and single insert port plus real eviction reporting. Sets are parametrised (1<<SETBITS) and data width is parametrised; replacement is true LRU per set. Sits between the core's load path and the single-read-port memory. Victims go out on the eviction port so a write-back buffer or victim cache can capture them.

## Interface
- SETBITS, 2: number of sets = 1<<SETBITS; set index = adr[SETBITS-1:0], tag = adr[15:SETBITS]; legal 1..8.
- DWIDTH, 16: data word width.
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- raddr0  input  16  read address, port 0.
- re0  input  1  read enable, port 0.
- data_out0  output  DWIDTH  read data, port 0; valid only when valid0=1.
- valid0  output  1  port 0 hit, registered.
- raddr1, re1, data_out1, valid1: identical port 1.
- insert_adr  input  16  insert address.
- data_in  input  DWIDTH  insert data.
- valid_in  input  1  insert strobe, one word per cycle.
- evicted_adr  output  16  address of displaced line, {tag, set}.
- evicted_data  output  DWIDTH  data of displaced line.
- evicted_valid  output  1  one-cycle pulse: a valid line was displaced.

## Operation
- Storage per set: 2 ways × {valid, tag[15-SETBITS:0], data[DWIDTH-1:0]}, plus 1 LRU bit (names the way to replace next).
- Read, per port: hit = re && way w valid && tag match for w in {0,1}. Hit → data_out ← data[w], valid ← 1, and LRU ← ~w. Miss or re=0 → valid ← 0 and data_out holds its previous value.
- Reads sample array contents before any same-cycle insert (old data; no bypass).
- Insert (valid_in=1), in priority order:
  - tag present in way w: overwrite data[w]; LRU ← ~w; no eviction.
  - else an invalid way exists: fill it (way 0 first if both invalid); LRU ← other way; no eviction.
  - else: replace way LRU; evicted_adr ← {old tag, set}, evicted_data ← old data, evicted_valid ← 1; LRU ← ~victim.
- LRU update order within one cycle when several events touch the same set: port 0, then port 1, then insert; the last writer wins.
- At most one way per set is ever valid with a given tag (guaranteed by the tag-present insert rule).
- No write-allocate or dirty state; every victim is reported, and the consumer decides what to do with it.

## Timing
- Read latency: 1 cycle. Address and re are sampled at edge N; valid/data are visible after edge N until edge N+1.
- Insert takes effect at edge N. A read of the same address sampled at edge N misses (or returns old data); the read at edge N+1 hits.
- evicted_* register at the insert edge. evicted_valid is high for exactly one cycle unless the next insert also evicts (back-to-back pulses allowed). It deasserts on any cycle with no evicting insert.
- Reset (rst=1 at an edge): all valid bits ← 0, all LRU ← 0, valid0=valid1=evicted_valid=0, data_out0/1=0, evicted_adr=0, evicted_data=0. Reset overrides a concurrent insert or read; tags/data need not be cleared.
- Reset mid-stream: the first post-reset read of any address misses.

## Test plan
- Reset, then read 0x0010 on both ports → valid0=valid1=0; evicted_valid never asserts.
- SETBITS=2. Insert 0x0010/AAAA, next cycle read port0 0x0010, port1 0x0014 → cycle after: valid0=1, data_out0=AAAA, valid1=0.
- Insert 0x0010/AAAA, 0x0020/BBBB, read 0x0010 (0x0020 becomes LRU), insert 0x0030/CCCC → evicted_valid pulses 1 cycle with adr=0x0020, data=BBBB; later reads of 0x0010 → AAAA, 0x0030 → CCCC, 0x0020 → miss.
- Insert 0x0010/1111, then insert 0x0010/2222 → no eviction; read 0x0010 → 2222.
- Same cycle: insert 0x0040/DDDD and port0 read 0x0040 → valid0=0; the read one cycle later → valid0=1, DDDD.
- Fill set 1 (0x0011, 0x0021), assert rst together with insert 0x0031 → no evicted_valid; all subsequent reads miss.
